// File: rtl/lsh_pkg.sv
// Shared types and constants for the LSH window pipeline: nucleotide encoding,
// sequencer states and the window stride helper.
package lsh_pkg;

    typedef logic [1:0] nuc_t;

    localparam nuc_t NUC_A = 2'b00;
    localparam nuc_t NUC_C = 2'b01;
    localparam nuc_t NUC_G = 2'b10;
    localparam nuc_t NUC_T = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HASH,
        COMMIT,
        HRST,
        CALC,
        RESULT
    } seq_state_t;

    // Consecutive windows share KMER_SIZE-1 nucleotides.
    function automatic int unsigned calc_stride(input int unsigned window_size,
                                                input int unsigned kmer_size);
        return window_size - kmer_size + 1;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// Nucleotide window shift register: index 0 is the oldest nucleotide, new data
// enters at the top position.
module window_shift_reg
    import lsh_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = 128
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     shift,
    input  logic [1:0]               din,
    output logic [2*WINDOW_SIZE-1:0] window
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else if (clear) begin
            window <= {WINDOW_SIZE{NUC_A}};
        end else if (shift) begin
            window <= {din, window[2*WINDOW_SIZE-1:2]};
        end
    end

endmodule

// File: rtl/window_sequencer.sv
// Splits a nucleotide stream into overlapping windows, hands each to the hasher
// and issues insert/query/match commands to the stats block.
module window_sequencer
    import lsh_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = 128,
    parameter int unsigned KMER_SIZE   = 16
)
(
    input  logic                     clk,
    input  logic                     reset_window_sequencer_n,
    input  logic                     start,
    input  logic                     is_reference,
    input  logic                     nuc_valid,
    input  logic [1:0]               nuc_data,
    input  logic                     nuc_last,
    output logic                     nuc_ready,
    output logic [2*WINDOW_SIZE-1:0] window,
    output logic [31:0]              window_id,
    output logic                     ready_for_hashing,
    input  logic                     hashing_is_done,
    output logic                     reset_window_hasher,
    output logic                     reset_stats,
    output logic                     is_insert,
    output logic                     is_query,
    output logic                     calculate_matched_window,
    input  logic signed [31:0]       matched_window_id,
    output logic                     done,
    output logic                     match_found,
    output logic signed [31:0]       result_id
);

    localparam int unsigned STRIDE = calc_stride(WINDOW_SIZE, KMER_SIZE);
    localparam int unsigned CNT_W  = $clog2(WINDOW_SIZE + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    seq_state_t state, next_state;

    cnt_t beat_cnt;
    cnt_t cnt_inc;
    cnt_t fill_target;
    logic is_ref;
    logic last_seen;
    logic first_win;

    logic accept;
    logic beat;
    logic fill_end;
    logic finish_ref;
    logic take_result;
    logic next_window;

    assign cnt_inc     = beat_cnt + cnt_t'(1);
    assign fill_target = first_win ? cnt_t'(WINDOW_SIZE) : cnt_t'(STRIDE);

    always_ff @(posedge clk or negedge reset_window_sequencer_n) begin
        if (!reset_window_sequencer_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state               = state;
        nuc_ready                = 1'b0;
        ready_for_hashing        = 1'b0;
        reset_window_hasher      = 1'b0;
        reset_stats              = 1'b0;
        is_insert                = 1'b0;
        is_query                 = 1'b0;
        calculate_matched_window = 1'b0;
        accept                   = 1'b0;
        beat                     = 1'b0;
        fill_end                 = 1'b0;
        finish_ref               = 1'b0;
        take_result              = 1'b0;
        next_window              = 1'b0;

        case (state)
            IDLE: begin
                // Gated by reset so the clear pulses stay low while reset is held.
                if (start && reset_window_sequencer_n) begin
                    accept              = 1'b1;
                    reset_window_hasher = 1'b1;
                    reset_stats         = 1'b1;
                    next_state          = FILL;
                end
            end
            FILL: begin
                nuc_ready = 1'b1;
                if (nuc_valid) begin
                    beat = 1'b1;
                    if (nuc_last || cnt_inc == fill_target) begin
                        fill_end   = 1'b1;
                        next_state = HASH;
                    end
                end
            end
            HASH: begin
                ready_for_hashing = 1'b1;
                if (hashing_is_done) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                if (is_ref) begin
                    is_insert = 1'b1;
                end else begin
                    is_query = 1'b1;
                end
                if (!last_seen) begin
                    next_state = HRST;
                end else if (is_ref) begin
                    finish_ref = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = CALC;
                end
            end
            HRST: begin
                reset_window_hasher = 1'b1;
                next_window         = 1'b1;
                next_state          = FILL;
            end
            CALC: begin
                calculate_matched_window = 1'b1;
                next_state               = RESULT;
            end
            RESULT: begin
                take_result = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_window_sequencer_n) begin
        if (!reset_window_sequencer_n) begin
            beat_cnt    <= '0;
            window_id   <= '0;
            is_ref      <= 1'b0;
            last_seen   <= 1'b0;
            first_win   <= 1'b0;
            done        <= 1'b0;
            match_found <= 1'b0;
            result_id   <= '0;
        end else begin
            // done is registered so it lines up with the latched match result.
            done <= finish_ref || take_result;

            if (accept) begin
                beat_cnt  <= '0;
                window_id <= '0;
                is_ref    <= is_reference;
                last_seen <= 1'b0;
                first_win <= 1'b1;
            end

            if (beat) begin
                beat_cnt <= fill_end ? '0 : cnt_inc;
                if (nuc_last) begin
                    last_seen <= 1'b1;
                end
            end

            if (next_window) begin
                window_id <= window_id + 32'd1;
                first_win <= 1'b0;
            end

            if (finish_ref) begin
                match_found <= 1'b0;
            end

            if (take_result) begin
                result_id   <= matched_window_id;
                match_found <= (matched_window_id != -32'sd1);
            end
        end
    end

    window_shift_reg #(
        .WINDOW_SIZE (WINDOW_SIZE)
    ) u_window_shift_reg (
        .clk    (clk),
        .rst_n  (reset_window_sequencer_n),
        .clear  (accept),
        .shift  (beat),
        .din    (nuc_data),
        .window (window)
    );

endmodule

// File: tb/tb_window_sequencer.sv
// Randomized self-checking bench for window_sequencer; expected windows and
// command counts come from a sequence-level model of the windowing rules.
module tb_window_sequencer;

    localparam int W = 8;
    localparam int K = 3;
    localparam int S = W - K + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                start;
    logic                is_reference;
    logic                nuc_valid;
    logic [1:0]          nuc_data;
    logic                nuc_last;
    logic                nuc_ready;
    logic [2*W-1:0]      window;
    logic [31:0]         window_id;
    logic                ready_for_hashing;
    logic                hashing_is_done = 1'b0;
    logic                reset_window_hasher;
    logic                reset_stats;
    logic                is_insert;
    logic                is_query;
    logic                calculate_matched_window;
    logic signed [31:0]  matched_window_id;
    logic                done;
    logic                match_found;
    logic signed [31:0]  result_id;

    window_sequencer #(
        .WINDOW_SIZE (W),
        .KMER_SIZE   (K)
    ) dut (
        .clk                      (clk),
        .reset_window_sequencer_n (rst_n),
        .start                    (start),
        .is_reference             (is_reference),
        .nuc_valid                (nuc_valid),
        .nuc_data                 (nuc_data),
        .nuc_last                 (nuc_last),
        .nuc_ready                (nuc_ready),
        .window                   (window),
        .window_id                (window_id),
        .ready_for_hashing        (ready_for_hashing),
        .hashing_is_done          (hashing_is_done),
        .reset_window_hasher      (reset_window_hasher),
        .reset_stats              (reset_stats),
        .is_insert                (is_insert),
        .is_query                 (is_query),
        .calculate_matched_window (calculate_matched_window),
        .matched_window_id        (matched_window_id),
        .done                     (done),
        .match_found              (match_found),
        .result_id                (result_id)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0] seq [0:63];
    int seq_len = 0;

    int n_hash = 0, n_ins = 0, n_qry = 0, n_calc = 0, n_done = 0;
    int n_rst_h = 0, n_rst_s = 0;
    bit hasher_en  = 1'b1;
    int hash_delay = 3;
    int hash_cnt   = 0;
    logic rfh_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Window k ends at the beat min(W + k*S, len); positions before beat 0 read as A.
    function automatic logic [2*W-1:0] exp_window(input int k);
        logic [2*W-1:0] w;
        int e;
        w = '0;
        e = W + k * S;
        if (e > seq_len) e = seq_len;
        for (int p = 0; p < W; p++) begin
            int idx;
            idx = e - W + p;
            if (idx >= 0) w[2*p +: 2] = seq[idx];
        end
        return w;
    endfunction

    function automatic int num_windows(input int n);
        int nw;
        nw = 1;
        while (W + (nw - 1) * S < n) nw++;
        return nw;
    endfunction

    task automatic clear_counts();
        n_hash = 0; n_ins = 0; n_qry = 0; n_calc = 0; n_done = 0;
        n_rst_h = 0; n_rst_s = 0;
    endtask

    // Monitor plus hasher model: checks each window as it is presented for hashing.
    always @(negedge clk) begin
        if (!rst_n) begin
            rfh_prev        = 1'b0;
            hash_cnt        = 0;
            hashing_is_done = 1'b0;
        end else begin
            if (ready_for_hashing && !rfh_prev) begin
                chk("window", 64'(window), 64'(exp_window(n_hash)));
                chk("window_id", 64'(window_id), 64'(n_hash));
                n_hash++;
            end
            rfh_prev = ready_for_hashing;
            if (is_insert) n_ins++;
            if (is_query) n_qry++;
            if (calculate_matched_window) n_calc++;
            if (done) n_done++;
            if (reset_window_hasher) n_rst_h++;
            if (reset_stats) n_rst_s++;
            if (32'(is_insert) + 32'(is_query) + 32'(calculate_matched_window) > 1)
                chk("one_command", 64'(32'(is_insert) + 32'(is_query) + 32'(calculate_matched_window)), 64'd1);
            if (ready_for_hashing && hasher_en) begin
                hash_cnt++;
                hashing_is_done = (hash_cnt >= hash_delay);
            end else begin
                hash_cnt        = 0;
                hashing_is_done = 1'b0;
            end
        end
    end

    task automatic run_seq(input bit is_ref, input int n, input int mwid,
                           input bit stall, input bit extra_start, input bit use_pat);
        int  nw;
        int  i;
        int  cyc;
        bit  extra_done;
        extra_done = 1'b0;
        seq_len    = n;
        if (!use_pat) for (int j = 0; j < n; j++) seq[j] = 2'($urandom);
        clear_counts();
        matched_window_id = mwid;
        nw = num_windows(n);

        @(negedge clk);
        start        = 1'b1;
        is_reference = is_ref;
        nuc_valid    = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        is_reference = 1'($urandom);

        i   = 0;
        cyc = 0;
        while (i < n && cyc < 40 * n + 100) begin
            start     = 1'b0;
            nuc_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            nuc_data  = nuc_valid ? seq[i] : 2'($urandom);
            nuc_last  = nuc_valid ? (i == n - 1) : 1'($urandom);
            if (extra_start && !extra_done && nuc_ready && i >= n / 2) begin
                start        = 1'b1;
                is_reference = !is_ref;
                extra_done   = 1'b1;
            end
            if (nuc_valid && nuc_ready) i++;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        nuc_valid = 1'b0;
        nuc_last  = 1'b0;
        if (i < n) chk("beats_accepted", 64'(i), 64'(n));

        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
        if (done) begin
            chk("match_found", 64'(match_found), is_ref ? 64'd0 : 64'(mwid != -1));
            if (!is_ref) chk("result_id", 64'(result_id), 64'(mwid));
        end
        repeat (4) @(negedge clk);
        chk("n_hash", 64'(n_hash), 64'(nw));
        chk("n_insert", 64'(n_ins), is_ref ? 64'(nw) : 64'd0);
        chk("n_query", 64'(n_qry), is_ref ? 64'd0 : 64'(nw));
        chk("n_calc", 64'(n_calc), is_ref ? 64'd0 : 64'd1);
        chk("n_done", 64'(n_done), 64'd1);
        chk("n_reset_hasher", 64'(n_rst_h), 64'(nw));
        chk("n_reset_stats", 64'(n_rst_s), 64'd1);
    endtask

    task automatic reset_in_hash();
        int cyc;
        seq_len = 14;
        for (int j = 0; j < 14; j++) seq[j] = 2'($urandom);
        clear_counts();
        hasher_en = 1'b0;
        @(negedge clk);
        start        = 1'b1;
        is_reference = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < W; j++) begin
            nuc_valid = 1'b1;
            nuc_data  = seq[j];
            nuc_last  = 1'b0;
            @(negedge clk);
        end
        nuc_valid = 1'b0;
        cyc = 0;
        while (!ready_for_hashing && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("hash_reached", 64'(ready_for_hashing), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_flags", 64'({nuc_ready, ready_for_hashing, reset_window_hasher, reset_stats,
                              is_insert, is_query, calculate_matched_window, done, match_found}), 64'd0);
        chk("rst_window", 64'(window), 64'd0);
        chk("rst_window_id", 64'(window_id), 64'd0);
        chk("rst_result_id", 64'(result_id), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hasher_en = 1'b1;
        clear_counts();
        repeat (6) @(negedge clk);
        chk("post_reset_quiet", 64'(n_hash + n_ins + n_qry + n_calc + n_done + n_rst_h + n_rst_s), 64'd0);
        chk("post_reset_ready", 64'(nuc_ready), 64'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        start             = 1'b0;
        is_reference      = 1'b0;
        nuc_valid         = 1'b0;
        nuc_data          = 2'b00;
        nuc_last          = 1'b0;
        matched_window_id = 32'sd0;
        repeat (3) @(negedge clk);
        chk("reset_window", 64'(window), 64'd0);
        chk("reset_window_id", 64'(window_id), 64'd0);
        chk("reset_result_id", 64'(result_id), 64'd0);
        chk("reset_flags", 64'({nuc_ready, ready_for_hashing, done, match_found}), 64'd0);
        rst_n = 1'b1;
        clear_counts();
        repeat (4) @(negedge clk);
        chk("idle_quiet", 64'(n_rst_h + n_rst_s + n_ins + n_qry + n_done + 32'(nuc_ready)), 64'd0);

        hash_delay = 3;
        run_seq(1'b1, 14, 0, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 8; j++) seq[j] = 2'(j % 4);
        run_seq(1'b0, 8, 5, 1'b0, 1'b0, 1'b1);

        run_seq(1'b0, 8, -1, 1'b0, 1'b0, 1'b0);

        reset_in_hash();
        run_seq(1'b1, 14, 0, 1'b0, 1'b0, 1'b0);

        run_seq(1'b1, 3, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            hash_delay = $urandom_range(1, 5);
            run_seq(1'($urandom_range(0, 1)), $urandom_range(1, 30),
                    ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(0, 100)),
                    1'b1, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
